frame_mem_arbiter: RTL
======================

Name: frame_mem_arbiter

Overview:
Shares one single-port frame memory between two requesters. The write requester is the processed pixel stream from vp_top (valid/ready); the read requester is the display fetch side (request/address). Reads have priority, and a starvation guard guarantees the write stream forward progress. The write address is generated internally: raster order, wrapping per frame.

Parameters:
DW, 12, pixel data width
RL, 640, pixels per row
ROW, 480, rows per frame
AW, 19, memory address width (must satisfy 2^AW >= RL*ROW)
MAX_RD_RUN, 4, max consecutive read grants while a write is pending before one write slot is forced

Ports:
i_clk  in  1  system clock
i_rstn  in  1  asynchronous active-low reset
i_data_valid  in  1  write pixel valid from vp_top
i_data  in  DW  write pixel
o_data_ready  out  1  write accepted this cycle when high with i_data_valid
i_wr_sof  in  1  one-cycle pulse: next accepted pixel is frame pixel 0
i_rd_req  in  1  display read request
i_rd_addr  in  AW  display read address
o_rd_gnt  out  1  read issued to memory this cycle
o_rd_valid  out  1  read data valid (one cycle after o_rd_gnt)
o_rd_data  out  DW  read data
o_frame_done  out  1  one-cycle pulse after last pixel of a frame is written
o_mem_en  out  1  memory enable
o_mem_we  out  1  memory write enable
o_mem_addr  out  AW  memory address
o_mem_wdata  out  DW  memory write data
i_mem_rdata  in  DW  memory read data, 1-cycle latency

Behaviour:
- Reset (async assert, all regs): wr_addr=0, rd_run=0, o_rd_valid=0, o_rd_data=0, o_frame_done=0, rd_oob_q=0. Combinational outputs follow from register state and inputs: o_data_ready=1 when i_rd_req=0.
- Arbitration (combinational, per cycle):
  - force_wr = (rd_run == MAX_RD_RUN) && i_data_valid.
  - o_rd_gnt = i_rd_req && !force_wr.
  - o_data_ready = !o_rd_gnt. o_data_ready does not depend on i_data_valid when i_rd_req=0.
  - wr_fire = i_data_valid && o_data_ready.
- rd_run counter:
  - o_rd_gnt && i_data_valid: rd_run increments, saturating at MAX_RD_RUN.
  - Otherwise rd_run clears to 0. Any write grant or an idle write side resets it.
- Memory port:
  - o_rd_gnt: en=1, we=0, addr=i_rd_addr.
  - wr_fire: en=1, we=1, addr=wr_addr, wdata=i_data.
  - Neither: en=0, we=0, addr/wdata hold the write-path values.
- Read data path:
  - o_rd_valid registered = o_rd_gnt.
  - o_rd_data = i_mem_rdata when o_rd_valid, otherwise holds its last value.
- Out-of-range read (i_rd_addr >= RL*ROW):
  - Still granted with o_rd_gnt=1, but o_mem_en=0.
  - Next cycle o_rd_valid=1 with o_rd_data=0, tracked by registered flag rd_oob_q.
- Write address:
  - On wr_fire, wr_addr increments.
  - At RL*ROW-1 it wraps to 0 and o_frame_done pulses high for one cycle on the following cycle.
- i_wr_sof:
  - Without wr_fire in the same cycle: wr_addr <= 0.
  - With wr_fire in the same cycle: the pixel is written to address 0 and wr_addr <= 1.
  - SOF never raises o_frame_done by itself.
- Simultaneous read request and write valid with rd_run < MAX_RD_RUN: read wins, write stalls, and i_data must stay stable (vp_top contract).
- Throughput: exactly one memory access per cycle maximum, never two. A write stream with no read traffic sustains 1 pixel/cycle.
- Reset mid-frame: wr_addr returns to 0 and any in-flight read valid is dropped. No memory access occurs while i_rstn=0 (en forced 0).

Test Plan:
- Write-only: 8 pixels 0x001..0x008 after reset, i_rd_req=0 -> o_mem_we=1 on 8 consecutive cycles, addresses 0..7, o_data_ready stays 1.
- Read priority: i_rd_req=1 addr 0x00005 with i_data_valid=1, rd_run=0 -> o_rd_gnt=1, o_data_ready=0; next cycle o_rd_valid=1, o_rd_data=mem[5].
- Starvation guard: i_rd_req and i_data_valid held high, MAX_RD_RUN=4 -> pattern R,R,R,R,W repeating; a write fires every 5th cycle.
- Frame wrap: stream RL*ROW=307200 pixels -> last write at addr 307199, o_frame_done pulses once the next cycle, next pixel goes to addr 0.
- SOF collisions: i_wr_sof with wr_addr=100 and no valid -> next write goes to addr 0; i_wr_sof with wr_fire -> writes addr 0, next to addr 1.
- Out-of-range read and async reset: i_rd_addr=307200 -> o_mem_en=0, next cycle o_rd_valid=1 with data 0x000; assert i_rstn=0 mid-stream -> o_rd_valid=0 immediately, wr_addr=0 after release.

Source files
------------

// File: rtl/frame_mem_arbiter.sv
// rtl/frame_mem_arbiter.sv - single-port frame memory arbiter: display reads vs. raster pixel writes
module frame_mem_arbiter #(
    parameter int DW         = 12,
    parameter int RL         = 640,
    parameter int ROW        = 480,
    parameter int AW         = 19,
    parameter int MAX_RD_RUN = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_data_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_data_ready,
    input  logic          i_wr_sof,
    input  logic          i_rd_req,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_gnt,
    output logic          o_rd_valid,
    output logic [DW-1:0] o_rd_data,
    output logic          o_frame_done,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int              FRAME     = RL * ROW;
    localparam logic [AW:0]     FRAME_SZ  = (AW+1)'(FRAME);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(FRAME - 1);
    localparam int              RUN_W     = $clog2(MAX_RD_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RD_RUN);

    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [RUN_W-1:0] rd_run_q, rd_run_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_oob_q, rd_oob_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;
    logic             frame_done_q, frame_done_d;

    logic          force_wr;
    logic          wr_fire;
    logic          rd_oob;
    logic [AW-1:0] eff_wr_addr;
    logic [DW-1:0] rd_out;

    assign force_wr     = (rd_run_q == RUN_MAX) && i_data_valid;
    assign o_rd_gnt     = i_rd_req && !force_wr;
    assign o_data_ready = !o_rd_gnt;
    assign wr_fire      = i_data_valid && o_data_ready;
    assign rd_oob       = {1'b0, i_rd_addr} >= FRAME_SZ;

    // A SOF pulse coinciding with an accepted pixel places that pixel at address 0.
    assign eff_wr_addr  = i_wr_sof ? '0 : wr_addr_q;

    // Out-of-range reads are acknowledged but never reach the memory.
    assign o_mem_en     = i_rstn && ((o_rd_gnt && !rd_oob) || wr_fire);
    assign o_mem_we     = i_rstn && wr_fire;
    assign o_mem_addr   = o_rd_gnt ? i_rd_addr : eff_wr_addr;
    assign o_mem_wdata  = i_data;

    assign rd_out       = rd_oob_q ? '0 : i_mem_rdata;
    assign o_rd_valid   = rd_valid_q;
    assign o_rd_data    = rd_valid_q ? rd_out : rd_data_q;
    assign o_frame_done = frame_done_q;

    always_comb begin
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;
        if (wr_fire) begin
            if (eff_wr_addr == LAST_ADDR) begin
                wr_addr_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                wr_addr_d = eff_wr_addr + 1'b1;
            end
        end else if (i_wr_sof) begin
            wr_addr_d = '0;
        end

        rd_run_d = '0;
        if (o_rd_gnt && i_data_valid) begin
            rd_run_d = (rd_run_q == RUN_MAX) ? RUN_MAX : rd_run_q + 1'b1;
        end

        rd_valid_d = o_rd_gnt;
        rd_oob_d   = o_rd_gnt && rd_oob;
        rd_data_d  = rd_valid_q ? rd_out : rd_data_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_addr_q    <= '0;
            rd_run_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_oob_q     <= 1'b0;
            rd_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_addr_q    <= wr_addr_d;
            rd_run_q     <= rd_run_d;
            rd_valid_q   <= rd_valid_d;
            rd_oob_q     <= rd_oob_d;
            rd_data_q    <= rd_data_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
